niosii_system_sysid_checker: RTL and testbench
==============================================

NIOSII_SYSTEM_SYSID_CHECKER -- requirements
Module: niosII_system_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, value required at sysid word 0 (system ID).
REQ-002 Parameter EXPECTED_TIMESTAMP, default 1486253148, value required at sysid word 1 (generation timestamp).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles per read transaction before abort; legal range 2..65535.
REQ-004 clock  input  1  sole clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse; requests a re-check.
REQ-007 avm_address  output  1  Avalon-MM master word address to sysid slave (0=ID, 1=timestamp).
REQ-008 avm_read  output  1  Avalon-MM read request.
REQ-009 avm_waitrequest  input  1  slave stall; tie low for a zero-wait slave.
REQ-010 avm_readdatavalid  input  1  read data qualifier.
REQ-011 avm_readdata  input  32  read data.
REQ-012 id_value / ts_value  output  32 each  last captured ID / timestamp.
REQ-013 busy  output  1  check in progress.
REQ-014 done  output  1  check finished (sticky until next check starts).
REQ-015 sys_ok  output  1  done with both words matching and no timeout.
REQ-016 timeout_err  output  1  a read exceeded TIMEOUT_CYCLES (sticky until next check starts).

Function
REQ-017 FSM states SHALL be IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
REQ-018 First cycle after reset deasserts SHALL leave IDLE for REQ_ID automatically (self-check at boot) with no start pulse.
REQ-019 In IDLE, start=1 SHALL move to REQ_ID next cycle; start is ignored in all other states.
REQ-020 Entering REQ_ID SHALL clear done, sys_ok, timeout_err; busy=1 in every state except IDLE.
REQ-021 REQ_x: avm_read=1, avm_address=0 (ID) or 1 (TS); held constant while avm_waitrequest=1; on waitrequest=0 go to WAIT_x next cycle.
REQ-022 avm_read SHALL be 0 outside REQ_ID/REQ_TS; avm_address SHALL be 0 when avm_read=0.
REQ-023 WAIT_x: on avm_readdatavalid=1 capture avm_readdata into id_value/ts_value; WAIT_ID->REQ_TS, WAIT_TS->FINISH.
REQ-024 readdatavalid coincident with the accepting REQ_x cycle SHALL be captured (zero-latency slave); FSM then skips WAIT_x.
REQ-025 readdatavalid in IDLE/FINISH SHALL be ignored.
REQ-026 16-bit timeout counter SHALL clear on entering each REQ_x, increment every cycle in REQ_x/WAIT_x, and when it reaches TIMEOUT_CYCLES-1 without completion set timeout_err=1 and go to FINISH.
REQ-027 FINISH (one cycle): done=1, sys_ok=(id_value==EXPECTED_ID)&&(ts_value==EXPECTED_TIMESTAMP)&&!timeout_err, full 32-bit equality; then IDLE.
REQ-028 Minimum check latency with zero-wait, zero-latency slave: done asserts 3 cycles after leaving IDLE.

Reset
REQ-029 reset=1 SHALL force IDLE within one clock edge, including mid-transaction; pending readdatavalid after reset SHALL be ignored.
REQ-030 Reset values: avm_read=0, avm_address=0, id_value=0, ts_value=0, busy=0, done=0, sys_ok=0, timeout_err=0, timeout counter=0.

Structure
REQ-031 State encoding, word offsets (ID=0, TS=1) and counter width SHALL live in shared package niosII_system_sysid_pkg.
REQ-032 Timeout counter SHALL be sub-module niosII_system_sysid_timeout (clear, enable, terminal-count output).

Verification
REQ-033 Reset release, zero-wait slave returning 0 then 1486253148 -> done=1, sys_ok=1 3 cycles after leaving IDLE, id_value=0, ts_value=1486253148.
REQ-034 Slave returns timestamp 1486253149 -> done=1, sys_ok=0, timeout_err=0, ts_value=1486253149.
REQ-035 waitrequest held 5 cycles on ID read -> avm_read/avm_address stable all 5 cycles, single capture, sys_ok=1.
REQ-036 TIMEOUT_CYCLES=16, readdatavalid never asserted on TS read -> timeout_err=1, done=1, sys_ok=0 at count 15; next start clears flags and re-checks successfully.
REQ-037 reset pulsed while in WAIT_TS, stray readdatavalid the following cycle -> all outputs at reset values, value not captured, automatic re-check follows.
REQ-038 start pulsed during busy -> ignored; exactly two reads issued per check.

Source files
------------

// File: rtl/niosii_system_sysid_pkg.sv
// Shared definitions for the sysid checker: FSM state encoding, the word
// offsets of the sysid slave and the width of the per-read timeout counter.
package niosii_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  // Word addresses inside the sysid slave.
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Timeout counter width; TIMEOUT_CYCLES must fit (2..65535).
  localparam int TMO_W = 16;

endpackage

// File: rtl/niosii_system_sysid_avm_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the sysid
// slave.
//   avm_address        master -> slave  word address (0 = ID, 1 = timestamp)
//   avm_read           master -> slave  read request
//   avm_waitrequest    slave -> master  stall
//   avm_readdatavalid  slave -> master  read data qualifier
//   avm_readdata       slave -> master  32-bit read data
//
// Handshake: a read is issued while avm_read=1; avm_address and avm_read stay
// constant while avm_waitrequest=1, and the command is accepted on the first
// rising edge where avm_read=1 and avm_waitrequest=0. Data is taken on any
// later edge (or the accepting edge itself) where avm_readdatavalid=1.
interface niosii_system_sysid_avm_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdatavalid, avm_readdata
  );
endinterface

// File: rtl/niosii_system_sysid_timeout.sv
// Per-read timeout counter.
//   clock, reset  clock and synchronous active-high reset
//   clear_i       restart from zero (has priority over enable_i)
//   enable_i      count one cycle
//   count_o       current count
//   tc_o          count has reached TIMEOUT_CYCLES-1
module niosii_system_sysid_timeout
  import niosii_system_sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [TMO_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign tc_o    = (cnt_q == TC_VAL);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Reads the two sysid words (system ID, generation timestamp) over Avalon-MM
// and compares them with the values this build expects. A check runs once
// automatically after reset and again on every start pulse while idle.
//   clock, reset       clock, synchronous active-high reset
//   start              single-cycle re-check request (honoured only in IDLE)
//   avm                Avalon-MM master port to the sysid slave
//   id_value/ts_value  last captured ID / timestamp words
//   busy               check in progress (any state but IDLE)
//   done               check finished, sticky until the next check starts
//   sys_ok             done, both words matched, no timeout
//   timeout_err        a read took TIMEOUT_CYCLES cycles, sticky
//   dbg_state_o        current FSM state
//   dbg_tmo_count_o    current timeout counter value
module niosii_system_sysid_checker
  import niosii_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486253148,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  niosii_system_sysid_avm_if.master  avm,
  output logic [31:0]                id_value,
  output logic [31:0]                ts_value,
  output logic                       busy,
  output logic                       done,
  output logic                       sys_ok,
  output logic                       timeout_err,
  output state_e                     dbg_state_o,
  output logic [TMO_W-1:0]           dbg_tmo_count_o
);

  state_e      state_q, state_d;
  logic        boot_q;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic        done_q, done_d, ok_q, ok_d, terr_q, terr_d;
  logic        is_ts;
  logic        tmo_clear, tmo_en, tmo_tc;

  // The ID and timestamp phases share the same request/wait behaviour; only
  // the address, the capture register and the follow-on state differ.
  assign is_ts = (state_q == ST_REQ_TS) || (state_q == ST_WAIT_TS);

  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    ts_d            = ts_q;
    done_d          = done_q;
    ok_d            = ok_q;
    terr_d          = terr_q;
    avm.avm_read    = 1'b0;
    avm.avm_address = ADDR_ID;

    case (state_q)
      ST_IDLE: begin
        // boot_q is only set in the first cycle after reset: boot self-check.
        if (boot_q || start) begin
          state_d = ST_REQ_ID;
          done_d  = 1'b0;
          ok_d    = 1'b0;
          terr_d  = 1'b0;
        end
      end

      ST_REQ_ID, ST_REQ_TS: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = is_ts ? ADDR_TS : ADDR_ID;
        if (!avm.avm_waitrequest && avm.avm_readdatavalid) begin
          // Zero-latency slave: data arrives with the accept, skip WAIT.
          if (is_ts) ts_d = avm.avm_readdata;
          else       id_d = avm.avm_readdata;
          state_d = is_ts ? ST_FINISH : ST_REQ_TS;
        end else if (tmo_tc) begin
          terr_d  = 1'b1;
          state_d = ST_FINISH;
        end else if (!avm.avm_waitrequest) begin
          state_d = is_ts ? ST_WAIT_TS : ST_WAIT_ID;
        end
      end

      ST_WAIT_ID, ST_WAIT_TS: begin
        if (avm.avm_readdatavalid) begin
          if (is_ts) ts_d = avm.avm_readdata;
          else       id_d = avm.avm_readdata;
          state_d = is_ts ? ST_FINISH : ST_REQ_TS;
        end else if (tmo_tc) begin
          terr_d  = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        ok_d    = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP) && !terr_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The timeout budget restarts for each read, on the edge entering REQ_x.
  assign tmo_clear = ((state_d == ST_REQ_ID) && (state_q != ST_REQ_ID)) ||
                     ((state_d == ST_REQ_TS) && (state_q != ST_REQ_TS));
  assign tmo_en    = (state_q == ST_REQ_ID) || (state_q == ST_WAIT_ID) ||
                     (state_q == ST_REQ_TS) || (state_q == ST_WAIT_TS);

  niosii_system_sysid_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (tmo_clear),
    .enable_i (tmo_en),
    .count_o  (dbg_tmo_count_o),
    .tc_o     (tmo_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      boot_q  <= 1'b1;
      id_q    <= '0;
      ts_q    <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
      id_q    <= id_d;
      ts_q    <= ts_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      terr_q  <= terr_d;
    end
  end

  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign sys_ok      = ok_q;
  assign timeout_err = terr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
module tb_niosii_system_sysid_checker;
  import niosii_system_sysid_pkg::*;

  localparam logic [31:0] TS_OK  = 32'd1486253148;
  localparam logic [31:0] TS_BAD = 32'd1486253149;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_t = 1'b0;
  always #5 clock = ~clock;

  // ---------------- main DUT (default parameters) ----------------
  niosii_system_sysid_avm_if avm_m ();
  logic [31:0] id_value, ts_value;
  logic busy, done, sys_ok, timeout_err;
  state_e st;
  logic [TMO_W-1:0] tcnt;

  niosii_system_sysid_checker dut (
    .clock(clock), .reset(reset), .start(start), .avm(avm_m),
    .id_value(id_value), .ts_value(ts_value), .busy(busy), .done(done),
    .sys_ok(sys_ok), .timeout_err(timeout_err),
    .dbg_state_o(st), .dbg_tmo_count_o(tcnt)
  );

  // Slave model: optional waitrequest on the ID read, zero-latency data.
  int          cfg_id_wait = 0;
  logic        cfg_ts_silent = 1'b0;
  logic [31:0] cfg_id_data = 32'd0;
  logic [31:0] cfg_ts_data = TS_OK;
  logic        stray_rdv = 1'b0;
  logic [31:0] stray_data = 32'hDEADBEEF;
  int          wr_cnt = 0;
  int          acc_cnt = 0;
  logic        m_wait;

  assign m_wait = avm_m.avm_read && (avm_m.avm_address == 1'b0) && (wr_cnt < cfg_id_wait);
  assign avm_m.avm_waitrequest   = m_wait;
  assign avm_m.avm_readdatavalid = stray_rdv ||
         (avm_m.avm_read && !m_wait && !(avm_m.avm_address && cfg_ts_silent));
  assign avm_m.avm_readdata = stray_rdv ? stray_data :
                              m_wait ? 32'hBAD0BAD0 :
                              (avm_m.avm_address ? cfg_ts_data : cfg_id_data);

  always @(posedge clock) begin
    if (!avm_m.avm_read) wr_cnt <= 0;
    else if (m_wait)     wr_cnt <= wr_cnt + 1;
    if (avm_m.avm_read && !m_wait) acc_cnt <= acc_cnt + 1;
  end

  // ---------------- second DUT, short timeout ----------------
  niosii_system_sysid_avm_if avm_t ();
  logic [31:0] id_value_t, ts_value_t;
  logic busy_t, done_t, sys_ok_t, timeout_err_t;
  state_e st_t;
  logic [TMO_W-1:0] tcnt_t;
  logic t_ts_silent = 1'b0;

  niosii_system_sysid_checker #(.TIMEOUT_CYCLES(16)) dut_t (
    .clock(clock), .reset(reset), .start(start_t), .avm(avm_t),
    .id_value(id_value_t), .ts_value(ts_value_t), .busy(busy_t), .done(done_t),
    .sys_ok(sys_ok_t), .timeout_err(timeout_err_t),
    .dbg_state_o(st_t), .dbg_tmo_count_o(tcnt_t)
  );

  assign avm_t.avm_waitrequest   = 1'b0;
  assign avm_t.avm_readdatavalid = avm_t.avm_read && !(avm_t.avm_address && t_ts_silent);
  assign avm_t.avm_readdata      = avm_t.avm_address ? TS_OK : 32'd0;

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit sel);
    @(negedge clock);
    if (sel) start_t = 1'b1; else start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    start_t = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sel ? done_t : done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_checks++; if (st !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", st, ST_IDLE); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (sys_ok !== 1'b0) begin n_errors++; $display("FAIL reset_sys_ok: got %b expected 0", sys_ok); end
    n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    n_checks++; if (id_value !== 32'd0 || ts_value !== 32'd0) begin n_errors++; $display("FAIL reset_values: got id %0h ts %0h expected 0 0", id_value, ts_value); end
    n_checks++; if (avm_m.avm_read !== 1'b0 || avm_m.avm_address !== 1'b0) begin n_errors++; $display("FAIL reset_avm: got read %b addr %b expected 0 0", avm_m.avm_read, avm_m.avm_address); end
    n_checks++; if (tcnt !== 16'd0) begin n_errors++; $display("FAIL reset_counter: got %0d expected 0", tcnt); end
  endtask

  task automatic test_boot_check;
    int k;
    reset = 1'b0;
    @(negedge clock);  // first edge after release leaves IDLE with no start
    n_checks++; if (st !== ST_REQ_ID || busy !== 1'b1) begin n_errors++; $display("FAIL boot_req_id: got state %0d busy %b expected %0d 1", st, busy, ST_REQ_ID); end
    n_checks++; if (avm_m.avm_read !== 1'b1 || avm_m.avm_address !== 1'b0) begin n_errors++; $display("FAIL boot_id_read: got read %b addr %b expected 1 0", avm_m.avm_read, avm_m.avm_address); end
    k = 0;
    while (!done && k < 20) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        n_checks++; if (avm_m.avm_read !== 1'b1 || avm_m.avm_address !== 1'b1) begin n_errors++; $display("FAIL boot_ts_read: got read %b addr %b expected 1 1", avm_m.avm_read, avm_m.avm_address); end
      end
    end
    n_checks++; if (k != 3) begin n_errors++; $display("FAIL boot_latency: got %0d expected 3", k); end
    n_checks++; if (done !== 1'b1 || sys_ok !== 1'b1 || timeout_err !== 1'b0) begin n_errors++; $display("FAIL boot_flags: got done %b ok %b terr %b expected 1 1 0", done, sys_ok, timeout_err); end
    n_checks++; if (id_value !== 32'd0 || ts_value !== TS_OK) begin n_errors++; $display("FAIL boot_values: got id %0d ts %0d expected 0 %0d", id_value, ts_value, TS_OK); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL boot_busy: got %b expected 0", busy); end
  endtask

  task automatic test_ts_mismatch;
    bit ok;
    int a0;
    cfg_ts_data = TS_BAD;
    a0 = acc_cnt;
    pulse_start(1'b0);
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mismatch_done_clear: got %b expected 0", done); end
    wait_done(1'b0, 50, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL mismatch_done_wait: got no done expected done within 50 cycles"); end
    n_checks++; if (sys_ok !== 1'b0 || timeout_err !== 1'b0) begin n_errors++; $display("FAIL mismatch_flags: got ok %b terr %b expected 0 0", sys_ok, timeout_err); end
    n_checks++; if (ts_value !== TS_BAD) begin n_errors++; $display("FAIL mismatch_ts: got %0d expected %0d", ts_value, TS_BAD); end
    n_checks++; if (acc_cnt - a0 != 2) begin n_errors++; $display("FAIL mismatch_reads: got %0d expected 2", acc_cnt - a0); end
    cfg_ts_data = TS_OK;
  endtask

  task automatic test_waitrequest;
    bit ok;
    int a0;
    cfg_id_wait = 5;
    a0 = acc_cnt;
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (avm_m.avm_read !== 1'b1 || avm_m.avm_address !== 1'b0 || st !== ST_REQ_ID) begin
        n_errors++;
        $display("FAIL wait_stable_%0d: got read %b addr %b state %0d expected 1 0 %0d", i, avm_m.avm_read, avm_m.avm_address, st, ST_REQ_ID);
      end
      @(negedge clock);
    end
    wait_done(1'b0, 50, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL wait_done_wait: got no done expected done within 50 cycles"); end
    n_checks++; if (sys_ok !== 1'b1 || id_value !== 32'd0) begin n_errors++; $display("FAIL wait_result: got ok %b id %0h expected 1 0", sys_ok, id_value); end
    n_checks++; if (acc_cnt - a0 != 2) begin n_errors++; $display("FAIL wait_reads: got %0d expected 2", acc_cnt - a0); end
    cfg_id_wait = 0;
  endtask

  task automatic test_start_busy;
    bit ok;
    bit seen_busy;
    int a0, a1;
    cfg_id_wait = 3;
    a0 = acc_cnt;
    pulse_start(1'b0);
    start = 1'b1;  // held across two busy cycles, must be ignored
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    wait_done(1'b0, 50, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL busy_done_wait: got no done expected done within 50 cycles"); end
    n_checks++; if (acc_cnt - a0 != 2) begin n_errors++; $display("FAIL busy_reads: got %0d expected 2", acc_cnt - a0); end
    n_checks++; if (sys_ok !== 1'b1) begin n_errors++; $display("FAIL busy_sys_ok: got %b expected 1", sys_ok); end
    a1 = acc_cnt;
    seen_busy = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (busy) seen_busy = 1'b1;
    end
    n_checks++; if (seen_busy || acc_cnt != a1) begin n_errors++; $display("FAIL busy_no_recheck: got busy %b reads %0d expected 0 0", seen_busy, acc_cnt - a1); end
    cfg_id_wait = 0;
  endtask

  task automatic test_timeout;
    bit ok;
    int n, w;
    logic [TMO_W-1:0] last;
    t_ts_silent = 1'b1;
    pulse_start(1'b1);
    w = 0;
    while (st_t !== ST_REQ_TS && w < 20) begin @(negedge clock); w++; end
    n_checks++; if (st_t !== ST_REQ_TS) begin n_errors++; $display("FAIL tmo_reach_req_ts: got %0d expected %0d", st_t, ST_REQ_TS); end
    n = 0;
    last = '0;
    while ((st_t == ST_REQ_TS || st_t == ST_WAIT_TS) && n < 100) begin
      last = tcnt_t;
      n++;
      @(negedge clock);
    end
    n_checks++; if (st_t !== ST_FINISH) begin n_errors++; $display("FAIL tmo_finish: got %0d expected %0d", st_t, ST_FINISH); end
    n_checks++; if (n != 16 || last !== 16'd15) begin n_errors++; $display("FAIL tmo_cycles: got %0d cycles last count %0d expected 16 15", n, last); end
    n_checks++; if (timeout_err_t !== 1'b1) begin n_errors++; $display("FAIL tmo_err_set: got %b expected 1", timeout_err_t); end
    @(negedge clock);
    n_checks++; if (done_t !== 1'b1 || sys_ok_t !== 1'b0 || timeout_err_t !== 1'b1) begin n_errors++; $display("FAIL tmo_flags: got done %b ok %b terr %b expected 1 0 1", done_t, sys_ok_t, timeout_err_t); end
    t_ts_silent = 1'b0;
    pulse_start(1'b1);
    n_checks++; if (timeout_err_t !== 1'b0 || done_t !== 1'b0) begin n_errors++; $display("FAIL tmo_clear: got terr %b done %b expected 0 0", timeout_err_t, done_t); end
    wait_done(1'b1, 50, ok);
    n_checks++; if (!ok || sys_ok_t !== 1'b1 || timeout_err_t !== 1'b0) begin n_errors++; $display("FAIL tmo_recheck: got done %b ok %b terr %b expected 1 1 0", ok, sys_ok_t, timeout_err_t); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int w;
    cfg_ts_silent = 1'b1;
    pulse_start(1'b0);
    w = 0;
    while (st !== ST_WAIT_TS && w < 20) begin @(negedge clock); w++; end
    n_checks++; if (st !== ST_WAIT_TS) begin n_errors++; $display("FAIL rmid_reach_wait_ts: got %0d expected %0d", st, ST_WAIT_TS); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (st !== ST_IDLE || busy !== 1'b0 || done !== 1'b0 || sys_ok !== 1'b0 || timeout_err !== 1'b0) begin n_errors++; $display("FAIL rmid_flags: got state %0d busy %b done %b ok %b terr %b expected 0 0 0 0 0", st, busy, done, sys_ok, timeout_err); end
    n_checks++; if (id_value !== 32'd0 || ts_value !== 32'd0 || tcnt !== 16'd0) begin n_errors++; $display("FAIL rmid_values: got id %0h ts %0h cnt %0d expected 0 0 0", id_value, ts_value, tcnt); end
    n_checks++; if (avm_m.avm_read !== 1'b0 || avm_m.avm_address !== 1'b0) begin n_errors++; $display("FAIL rmid_avm: got read %b addr %b expected 0 0", avm_m.avm_read, avm_m.avm_address); end
    reset = 1'b0;
    cfg_ts_silent = 1'b0;
    stray_rdv = 1'b1;
    @(negedge clock);
    stray_rdv = 1'b0;
    n_checks++; if (id_value !== 32'd0 || ts_value !== 32'd0) begin n_errors++; $display("FAIL rmid_stray: got id %0h ts %0h expected 0 0", id_value, ts_value); end
    n_checks++; if (st !== ST_REQ_ID) begin n_errors++; $display("FAIL rmid_auto: got %0d expected %0d", st, ST_REQ_ID); end
    wait_done(1'b0, 50, ok);
    n_checks++; if (!ok || sys_ok !== 1'b1 || ts_value !== TS_OK) begin n_errors++; $display("FAIL rmid_recheck: got done %b ok %b ts %0d expected 1 1 %0d", ok, sys_ok, ts_value, TS_OK); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_boot_check();
    test_ts_mismatch();
    test_waitrequest();
    test_start_busy();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
